// File: rtl/result_capture_module.sv
// Captures one frame of N_RESULTS signed scores from AXI-Stream into a register bank with a
// running argmax; PS reads scores/status/argmax and re-arms the block over AXI4-Lite.
module result_capture_module #(
  parameter int N_RESULTS  = 10,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  s_axi_aclk,
  input  logic                  s_axi_aresetn,
  input  logic [ADDR_WIDTH-1:0] S_AXI_awaddr,
  input  logic [2:0]            S_AXI_awprot,
  input  logic                  S_AXI_awvalid,
  output logic                  S_AXI_awready,
  input  logic [DATA_WIDTH-1:0] S_AXI_wdata,
  input  logic [3:0]            S_AXI_wstrb,
  input  logic                  S_AXI_wvalid,
  output logic                  S_AXI_wready,
  output logic [1:0]            S_AXI_bresp,
  output logic                  S_AXI_bvalid,
  input  logic                  S_AXI_bready,
  input  logic [ADDR_WIDTH-1:0] S_AXI_araddr,
  input  logic [2:0]            S_AXI_arprot,
  input  logic                  S_AXI_arvalid,
  output logic                  S_AXI_arready,
  output logic [DATA_WIDTH-1:0] S_AXI_rdata,
  output logic [1:0]            S_AXI_rresp,
  output logic                  S_AXI_rvalid,
  input  logic                  S_AXI_rready,
  input  logic [DATA_WIDTH-1:0] y_tdata,
  input  logic                  y_tvalid,
  output logic                  y_tready,
  input  logic                  y_tlast,
  output logic                  done
);

  localparam int CNT_W  = 7;
  localparam int IDX_W  = 6;
  localparam int WORD_W = ADDR_WIDTH - 2;

  localparam logic [WORD_W-1:0] W_STATUS  = WORD_W'(32'h40);
  localparam logic [WORD_W-1:0] W_ARGMAX  = WORD_W'(32'h41);
  localparam logic [WORD_W-1:0] W_CONTROL = WORD_W'(32'h42);

  typedef enum logic [1:0] {
    ST_ARMED   = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  state_t                        state_q;
  logic                          tready_q;
  logic                          done_q;
  logic [CNT_W-1:0]              cnt_q;
  logic                          short_q;
  logic                          long_q;
  logic [IDX_W-1:0]              argmax_q;
  logic signed [DATA_WIDTH-1:0]  max_q;
  logic [DATA_WIDTH-1:0]         res_q [N_RESULTS];

  logic                          awready_q;
  logic                          wready_q;
  logic                          bvalid_q;
  logic                          arready_q;
  logic                          rvalid_q;
  logic [DATA_WIDTH-1:0]         rdata_q;
  logic [DATA_WIDTH-1:0]         rdata_d;

  logic                          wr_hs;
  logic                          rd_hs;
  logic                          clr;
  logic                          beat_acc;
  logic                          last_idx;
  logic [WORD_W-1:0]             aw_word;
  logic [WORD_W-1:0]             ar_word;
  logic [DATA_WIDTH-1:0]         status_w;
  logic [DATA_WIDTH-1:0]         argmax_w;

  logic unused_ok;
  assign unused_ok = ^{S_AXI_awprot, S_AXI_arprot, S_AXI_wstrb[3:1],
                       S_AXI_awaddr[1:0], S_AXI_araddr[1:0], S_AXI_wdata[DATA_WIDTH-1:1]};

  assign aw_word  = S_AXI_awaddr[ADDR_WIDTH-1:2];
  assign ar_word  = S_AXI_araddr[ADDR_WIDTH-1:2];
  assign wr_hs    = awready_q & S_AXI_awvalid & S_AXI_wvalid;
  assign rd_hs    = arready_q & S_AXI_arvalid;
  assign clr      = wr_hs & (aw_word == W_CONTROL) & S_AXI_wstrb[0] & S_AXI_wdata[0];
  assign beat_acc = y_tvalid & tready_q;
  assign last_idx = (cnt_q == CNT_W'(N_RESULTS - 1));

  assign S_AXI_awready = awready_q;
  assign S_AXI_wready  = wready_q;
  assign S_AXI_bvalid  = bvalid_q;
  assign S_AXI_bresp   = 2'b00;
  assign S_AXI_arready = arready_q;
  assign S_AXI_rvalid  = rvalid_q;
  assign S_AXI_rdata   = rdata_q;
  assign S_AXI_rresp   = 2'b00;
  assign y_tready      = tready_q;
  assign done          = done_q;

  // Capture FSM. Clear wins over a beat landing in the same cycle, so that beat is dropped.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q  <= ST_ARMED;
      tready_q <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      argmax_q <= '0;
      max_q    <= '0;
      for (int k = 0; k < N_RESULTS; k++) res_q[k] <= '0;
    end else if (clr) begin
      state_q  <= ST_ARMED;
      tready_q <= 1'b1;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      argmax_q <= '0;
    end else begin
      if (state_q != ST_DONE) tready_q <= 1'b1;
      if (beat_acc) begin
        for (int k = 0; k < N_RESULTS; k++) begin
          if (cnt_q == CNT_W'(k)) res_q[k] <= y_tdata;
        end
        cnt_q <= cnt_q + CNT_W'(1);
        if (cnt_q == '0) begin
          max_q    <= y_tdata;
          argmax_q <= '0;
        end else if ($signed(y_tdata) > max_q) begin
          max_q    <= y_tdata;
          argmax_q <= cnt_q[IDX_W-1:0];
        end
        if (last_idx || y_tlast) begin
          state_q  <= ST_DONE;
          tready_q <= 1'b0;
          done_q   <= 1'b1;
          short_q  <= y_tlast & ~last_idx;
          long_q   <= ~y_tlast;
        end else begin
          state_q  <= ST_CAPTURE;
        end
      end
    end
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
    end else begin
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      if (S_AXI_awvalid && S_AXI_wvalid && !bvalid_q && !awready_q) begin
        awready_q <= 1'b1;
        wready_q  <= 1'b1;
      end
      if (wr_hs) bvalid_q <= 1'b1;
      else if (S_AXI_bready) bvalid_q <= 1'b0;
    end
  end

  always_comb begin
    status_w        = '0;
    status_w[0]     = done_q;
    status_w[1]     = (state_q == ST_CAPTURE);
    status_w[2]     = short_q;
    status_w[3]     = long_q;
    status_w[15:8]  = 8'(cnt_q);
    argmax_w        = '0;
    argmax_w[IDX_W-1:0] = argmax_q;
  end

  always_comb begin
    rdata_d = '0;
    for (int k = 0; k < N_RESULTS; k++) begin
      if (ar_word == WORD_W'(k)) rdata_d = res_q[k];
    end
    if (ar_word == W_STATUS) rdata_d = status_w;
    if (ar_word == W_ARGMAX) rdata_d = argmax_w;
  end

  // Read data is latched at the address handshake and held until the master takes it.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      arready_q <= 1'b0;
      if (S_AXI_arvalid && !rvalid_q && !arready_q) arready_q <= 1'b1;
      if (rd_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rdata_d;
      end else if (S_AXI_rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_result_capture_module.sv
// Directed bench for result_capture_module: stream frames, read back over AXI-Lite, compare.
module tb_result_capture_module;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] awaddr = '0;
  logic [2:0]  awprot = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [11:0] araddr = '0;
  logic [2:0]  arprot = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [31:0] y_tdata = '0;
  logic        y_tvalid = 1'b0;
  logic        y_tready;
  logic        y_tlast = 1'b0;
  logic        done;

  int n_vec = 0;
  int n_err = 0;

  logic        mon_en = 1'b0;
  logic        clr_hit = 1'b0;
  logic [31:0] post_q [$];
  logic [31:0] f2 [10];

  always #5 clk = ~clk;

  result_capture_module dut (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (rst_n),
    .S_AXI_awaddr  (awaddr),
    .S_AXI_awprot  (awprot),
    .S_AXI_awvalid (awvalid),
    .S_AXI_awready (awready),
    .S_AXI_wdata   (wdata),
    .S_AXI_wstrb   (wstrb),
    .S_AXI_wvalid  (wvalid),
    .S_AXI_wready  (wready),
    .S_AXI_bresp   (bresp),
    .S_AXI_bvalid  (bvalid),
    .S_AXI_bready  (bready),
    .S_AXI_araddr  (araddr),
    .S_AXI_arprot  (arprot),
    .S_AXI_arvalid (arvalid),
    .S_AXI_arready (arready),
    .S_AXI_rdata   (rdata),
    .S_AXI_rresp   (rresp),
    .S_AXI_rvalid  (rvalid),
    .S_AXI_rready  (rready),
    .y_tdata       (y_tdata),
    .y_tvalid      (y_tvalid),
    .y_tready      (y_tready),
    .y_tlast       (y_tlast),
    .done          (done)
  );

  // Beats after the clear handshake cycle form the new frame; the beat in that cycle is dropped.
  always @(negedge clk) begin
    if (mon_en) begin
      if (awvalid && awready) clr_hit = 1'b1;
      else if (clr_hit && y_tvalid && y_tready) post_q.push_back(y_tdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Leaves y_tvalid high so consecutive calls stream back to back.
  task automatic send_beat(input logic [31:0] d, input logic last);
    logic ok;
    ok = 1'b0;
    y_tdata  = d;
    y_tlast  = last;
    y_tvalid = 1'b1;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      if (y_tready) ok = 1'b1;
    end
    if (!ok) begin
      n_err++;
      $error("FAIL beat_timeout: observed no tready expected accept of %08h", d);
    end
    sync();
  endtask

  task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int bdly);
    logic ok;
    sync();
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      if (awready && wready) ok = 1'b1;
    end
    if (!ok) begin
      n_err++;
      $error("FAIL aw_timeout: observed no awready expected handshake at %03h", a);
    end
    sync();
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    check("bvalid_next", 32'(bvalid), 32'd1);
    for (int i = 0; i < bdly; i++) begin
      @(negedge clk);
      check("bvalid_held", 32'(bvalid), 32'd1);
    end
    check("bresp", 32'(bresp), 32'd0);
    sync();
    bready = 1'b1;
    sync();
    bready = 1'b0;
    @(negedge clk);
    check("bvalid_clr", 32'(bvalid), 32'd0);
    sync();
  endtask

  task automatic axi_read(input logic [11:0] a, input logic [31:0] exp, input string tag);
    logic ok;
    int   hold;
    repeat ($urandom_range(0, 50)) @(posedge clk);
    sync();
    araddr = a; arvalid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      if (arready) ok = 1'b1;
    end
    if (!ok) begin
      n_err++;
      $error("FAIL %s_ar_timeout: observed no arready expected handshake at %03h", tag, a);
    end
    sync();
    arvalid = 1'b0;
    @(negedge clk);
    check({tag, "_rvalid"}, 32'(rvalid), 32'd1);
    check(tag, rdata, exp);
    hold = $urandom_range(0, 3);
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      check({tag, "_held"}, {rvalid, rresp, rdata[28:0]}, {1'b1, 2'b00, exp[28:0]});
    end
    sync();
    rready = 1'b1;
    sync();
    rready = 1'b0;
  endtask

  initial begin
    logic seen;
    int   m;

    // Reset and release.
    repeat (30) @(posedge clk);
    @(negedge clk);
    check("rst_outs", {28'd0, awready, bvalid, rvalid, arready}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_tready_done", {30'd0, y_tready, done}, 32'd0);
    sync();
    rst_n = 1'b1;
    @(negedge clk);
    check("tready_before_edge", 32'(y_tready), 32'd0);
    @(negedge clk);
    check("tready_after_edge", 32'(y_tready), 32'd1);
    sync();
    axi_read(12'h100, 32'h0000_0000, "status_rst");
    check("done_rst", 32'(done), 32'd0);

    // Frame 0..9, tlast on the final beat.
    for (int i = 0; i < 10; i++) send_beat(32'(i), i == 9);
    y_tvalid = 1'b0; y_tlast = 1'b0;
    @(negedge clk);
    check("f1_done", 32'(done), 32'd1);
    check("f1_tready", 32'(y_tready), 32'd0);
    sync();
    axi_read(12'h00C, 32'd3, "f1_res3");
    axi_read(12'h104, 32'd9, "f1_argmax");
    axi_read(12'h100, 32'h0000_0A01, "f1_status");

    // Signed values with a tie at the maximum.
    f2 = '{32'd5, 32'hFFFF_FFF9, 32'd12, 32'd12, 32'd0, 32'hFFFF_FFFF, 32'd3, 32'd2, 32'd1, 32'd0};
    axi_write(12'h108, 32'd1, 4'h1, 3);
    for (int i = 0; i < 10; i++) send_beat(f2[i], i == 9);
    y_tvalid = 1'b0; y_tlast = 1'b0;
    axi_read(12'h104, 32'd2, "f2_argmax");
    axi_read(12'h004, 32'hFFFF_FFF9, "f2_res1");
    axi_read(12'h100, 32'h0000_0A01, "f2_status");

    // Short frame.
    axi_write(12'h108, 32'd1, 4'h1, 0);
    for (int i = 0; i < 4; i++) send_beat(32'h20 + 32'(i), i == 3);
    y_tvalid = 1'b0; y_tlast = 1'b0;
    axi_read(12'h100, 32'h0000_0405, "short_status");
    axi_read(12'h104, 32'd3, "short_argmax");

    // Long frame, with a mid-frame status read.
    axi_write(12'h108, 32'd1, 4'h1, 1);
    for (int i = 0; i < 3; i++) send_beat(32'h100 + 32'(i), 1'b0);
    y_tvalid = 1'b0;
    axi_read(12'h100, 32'h0000_0302, "mid_status");
    for (int i = 3; i < 10; i++) send_beat(32'h100 + 32'(i), 1'b0);
    y_tvalid = 1'b0;
    axi_read(12'h100, 32'h0000_0A09, "long_status");
    y_tdata = 32'hBAD; y_tvalid = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (y_tready) seen = 1'b1;
    end
    check("stall_11th", 32'(seen), 32'd0);
    sync();
    y_tvalid = 1'b0;
    axi_read(12'h100, 32'h0000_0A09, "long_status_after_stall");

    // Clear while streaming with gaps.
    axi_write(12'h108, 32'd1, 4'h1, 0);
    clr_hit = 1'b0;
    post_q.delete();
    mon_en = 1'b1;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          send_beat(32'h50 + 32'(i), i == 7);
          if (i < 3) begin
            y_tvalid = 1'b0;
            repeat ($urandom_range(0, 2)) sync();
          end
        end
        y_tvalid = 1'b0; y_tlast = 1'b0;
      end
      begin
        repeat (3) sync();
        axi_write(12'h108, 32'd1, 4'h1, 2);
      end
    join
    mon_en = 1'b0;
    m = post_q.size();
    if (m == 0) begin
      n_err++;
      $error("FAIL clr_stream: observed 0 post-clear beats expected at least 1");
    end else begin
      axi_read(12'h100, (32'(m) << 8) | 32'h5, "clr_status");
      axi_read(12'h000, post_q[0], "clr_res0");
      axi_read(12'h104, 32'(m - 1), "clr_argmax");
      // Ignored writes: result bank and CONTROL without strobe.
      axi_write(12'h000, 32'hDEAD, 4'hF, 2);
      axi_read(12'h000, post_q[0], "ro_res0");
      axi_write(12'h108, 32'd1, 4'h0, 1);
      axi_read(12'h100, (32'(m) << 8) | 32'h5, "nostrb_status");
    end
    axi_read(12'h024, 32'h109, "retained_res9");
    axi_read(12'h025, 32'h109, "unaligned_res9");
    axi_read(12'h0FC, 32'd0, "hole_0fc");
    axi_read(12'h10C, 32'd0, "hole_10c");
    axi_read(12'h108, 32'd0, "ctrl_reads0");

    // Reset mid-frame.
    axi_write(12'h108, 32'd1, 4'h1, 0);
    for (int i = 0; i < 3; i++) send_beat(32'h77 + 32'(i), 1'b0);
    y_tvalid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_outs", {30'd0, y_tready, done}, 32'd0);
    repeat (3) sync();
    rst_n = 1'b1;
    sync();
    axi_read(12'h000, 32'd0, "midrst_res0");
    axi_read(12'h100, 32'd0, "midrst_status");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
